// File: rtl/serial_mem_bridge.sv
// serial_mem_bridge
//   Bridges a byte-oriented serial link and a single-byte SRAM access port.
//   Host packet: CMD A2 A1 A0 N [data...]. CMD 'W' (0x57) writes, 'R' (0x52) reads.
//   The 20-bit address is {A2[3:0],A1,A0}. N+1 bytes are transferred and the
//   address auto-increments modulo 2^20. Writes end with an ack byte 'K'
//   (0x4B). Reads stream each SRAM byte back on the transmit side.
//
// Handshakes: rx_strobe and mem_finish are single-cycle pulses that are
//   sampled on the mclk edge where they are high. tx_strobe is only high while
//   tx_ready is high, and the byte counts as taken on that edge.
//   mem_begin_wr and mem_begin_rd are single-cycle pulses. mem_addr and
//   mem_data_wr stay stable until mem_finish arrives.
//
// Ports
//   mclk, reset                 clock, asynchronous active-high reset
//   rx_data/rx_strobe           received byte and its pulse
//   tx_ready/tx_data/tx_strobe  transmit handshake
//   mem_begin_wr/mem_begin_rd   SRAM access start pulses
//   mem_finish/mem_data_rd      SRAM completion pulse and read data
//   mem_addr/mem_data_wr        SRAM address and write data
//   busy                        high whenever the FSM is not idle
//   overrun                     sticky flag, set when an rx byte is dropped
//   dbg_state                   current FSM state, for observation
module serial_mem_bridge #(
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_strobe,
  output logic        mem_begin_wr,
  output logic        mem_begin_rd,
  input  logic        mem_finish,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_data_wr,
  input  logic [7:0]  mem_data_rd,
  output logic        busy,
  output logic        overrun,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR2, ADDR1, ADDR0, LEN, WDATA, WMEM, RMEM, RTX, ACK
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  state_t                  state_q;
  logic                    is_wr_q;
  logic [19:0]             addr_q;
  logic [7:0]              count_q;
  logic [7:0]              tx_data_q;
  logic [7:0]              wdata_q;
  logic                    begin_wr_q;
  logic                    begin_rd_q;
  logic                    overrun_q;
  logic [TIMEOUT_BITS-1:0] tmo_q;

  // The inter-byte timer only runs while the FSM waits on the host.
  // It does not run while the FSM waits on the SRAM or on the transmitter.
  logic tmo_active;
  logic rx_blocked;
  assign tmo_active = (state_q == ADDR2) || (state_q == ADDR1) || (state_q == ADDR0) ||
                      (state_q == LEN)   || (state_q == WDATA);
  assign rx_blocked = (state_q == WMEM) || (state_q == RMEM) ||
                      (state_q == RTX)  || (state_q == ACK);

  assign tx_strobe    = tx_ready && ((state_q == ACK) || (state_q == RTX));
  assign tx_data      = tx_data_q;
  assign mem_begin_wr = begin_wr_q;
  assign mem_begin_rd = begin_rd_q;
  assign mem_addr     = addr_q;
  assign mem_data_wr  = wdata_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      wdata_q    <= '0;
      begin_wr_q <= 1'b0;
      begin_rd_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      begin_wr_q <= 1'b0;
      begin_rd_q <= 1'b0;

      if (rx_strobe && rx_blocked) overrun_q <= 1'b1;

      if (rx_strobe || (state_q == IDLE)) tmo_q <= '0;
      else if (tmo_active)                tmo_q <= tmo_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (rx_strobe && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
            is_wr_q <= (rx_data == CMD_WR);
            state_q <= ADDR2;
          end
        end
        ADDR2: if (rx_strobe) begin
          addr_q[19:16] <= rx_data[3:0];
          state_q       <= ADDR1;
        end
        ADDR1: if (rx_strobe) begin
          addr_q[15:8] <= rx_data;
          state_q      <= ADDR0;
        end
        ADDR0: if (rx_strobe) begin
          addr_q[7:0] <= rx_data;
          state_q     <= LEN;
        end
        LEN: if (rx_strobe) begin
          count_q <= rx_data;
          if (is_wr_q) begin
            state_q <= WDATA;
          end else begin
            state_q    <= RMEM;
            begin_rd_q <= 1'b1;
          end
        end
        WDATA: if (rx_strobe) begin
          wdata_q    <= rx_data;
          begin_wr_q <= 1'b1;
          state_q    <= WMEM;
        end
        WMEM: if (mem_finish) begin
          if (count_q == 8'd0) begin
            tx_data_q <= ACK_BYTE;
            state_q   <= ACK;
          end else begin
            count_q <= count_q - 8'd1;
            addr_q  <= addr_q + 20'd1;
            state_q <= WDATA;
          end
        end
        ACK: if (tx_ready) state_q <= IDLE;
        RMEM: if (mem_finish) begin
          tx_data_q <= mem_data_rd;
          state_q   <= RTX;
        end
        RTX: if (tx_ready) begin
          if (count_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            count_q    <= count_q - 8'd1;
            addr_q     <= addr_q + 20'd1;
            begin_rd_q <= 1'b1;
            state_q    <= RMEM;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A silent host aborts the packet. A byte that arrives on the same
      // edge takes priority over the abort.
      if (tmo_active && (&tmo_q) && !rx_strobe) state_q <= IDLE;
    end
  end

endmodule
